// File: rtl/tdm_demux_4ch_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive-side demultiplexer.
//   tdm_state_t : alignment state (HUNT = searching for start of frame,
//                 RUN = aligned to the slot sequence)
//   TDM_WIDTH   : default bits per channel word
//   TDM_NCH     : default number of channels / slots per frame
// ----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

    localparam int TDM_WIDTH = 4;
    localparam int TDM_NCH   = 4;

endpackage : tdm_pkg

// File: rtl/tdm_demux_4ch_if.sv
// ----------------------------------------------------------------------------
// tdm_demux_4ch_if
// Bundles the serial input stream and the demultiplexed outputs of
// tdm_demux_4ch.
//   in_valid, in_sof, in_data : serial word stream from the 4:1 selector
//   ch_data, ch_valid         : per-channel last word and update pulse
//   frame_data, frame_valid   : last fully aligned frame and update pulse
//   sync_err, locked          : alignment error pulse and RUN indicator
// Modports:
//   master : the stream source / result consumer (drives the input side)
//   slave  : the demultiplexer itself
// ----------------------------------------------------------------------------
interface tdm_demux_4ch_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH
);

    logic                   in_valid;
    logic                   in_sof;
    logic [WIDTH-1:0]       in_data;
    logic [NCH*WIDTH-1:0]   ch_data;
    logic [NCH-1:0]         ch_valid;
    logic [NCH*WIDTH-1:0]   frame_data;
    logic                   frame_valid;
    logic                   sync_err;
    logic                   locked;

    modport master (
        output in_valid, in_sof, in_data,
        input  ch_data, ch_valid, frame_data, frame_valid, sync_err, locked
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output ch_data, ch_valid, frame_data, frame_valid, sync_err, locked
    );

endinterface : tdm_demux_4ch_if

// File: rtl/tdm_demux_4ch_slot_counter.sv
// ----------------------------------------------------------------------------
// tdm_slot_counter
// Modulo-NCH slot counter tracking the expected slot of the next word.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force the counter to 0 (highest priority)
//   load1      : force the counter to 1 (word just taken as slot 0)
//   inc        : advance by one, wrapping NCH-1 -> 0
//   slot       : current expected slot
// ----------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NCH   = TDM_NCH,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load1,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] slot
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

    // clr wins over load1 so a missing start of frame always parks the
    // counter at 0, ready for the next frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SEL_W'(1);
        end else if (inc) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + SEL_W'(1);
        end
    end

endmodule : tdm_slot_counter

// File: rtl/tdm_demux_4ch.sv
// ----------------------------------------------------------------------------
// tdm_demux_4ch
// Time-division demultiplexer: routes a serial stream of words, one per slot,
// back to NCH channel registers, assembles complete frames, detects loss of
// slot alignment and resynchronises on the next start of frame.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_4ch_if slave modport
//           in_valid/in_sof/in_data in, ch_data/ch_valid/frame_data/
//           frame_valid/sync_err/locked out (all outputs registered)
// ----------------------------------------------------------------------------
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_4ch_if.slave    bus
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

    tdm_state_t             state;
    tdm_state_t             state_next;
    logic [SEL_W-1:0]       slot;
    logic [SEL_W-1:0]       wr_idx;
    logic                   do_store;
    logic                   frame_done;
    logic                   err;
    logic                   cnt_load1;
    logic                   cnt_inc;
    logic                   cnt_clr;
    logic [NCH*WIDTH-1:0]   staging;
    logic [NCH*WIDTH-1:0]   staging_next;

    tdm_slot_counter #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .slot  (slot)
    );

    // Classify the incoming word against the expected slot. A start-of-frame
    // word is always stored as slot 0 (in HUNT it acquires alignment, in RUN
    // mid-frame it restarts the frame); a non-sof word where slot 0 was
    // expected means alignment is lost and the word is dropped.
    // staging_next is the staging register with the current word merged in,
    // so the frame published on the last slot already contains that word.
    always_comb begin
        state_next = state;
        do_store   = 1'b0;
        wr_idx     = '0;
        frame_done = 1'b0;
        err        = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        if (bus.in_valid) begin
            if (state == HUNT) begin
                if (bus.in_sof) begin
                    do_store   = 1'b1;
                    cnt_load1  = 1'b1;
                    state_next = RUN;
                end
            end else if (bus.in_sof) begin
                do_store = 1'b1;
                if (slot == '0) begin
                    cnt_inc = 1'b1;
                end else begin
                    cnt_load1 = 1'b1;
                    err       = 1'b1;
                end
            end else if (slot == '0) begin
                err        = 1'b1;
                cnt_clr    = 1'b1;
                state_next = HUNT;
            end else begin
                do_store   = 1'b1;
                wr_idx     = slot;
                cnt_inc    = 1'b1;
                frame_done = (slot == LAST_SLOT);
            end
        end

        staging_next = staging;
        if (do_store) begin
            staging_next[int'(wr_idx)*WIDTH +: WIDTH] = bus.in_data;
        end
    end

    // FSM state, channel registers, staging and frame registers. Pulses
    // default low each cycle; locked follows the state being entered so it
    // changes the cycle after the word that caused the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HUNT;
            staging         <= '0;
            bus.ch_data     <= '0;
            bus.ch_valid    <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
            bus.locked      <= 1'b0;
        end else begin
            state           <= state_next;
            bus.locked      <= (state_next == RUN);
            bus.sync_err    <= err;
            bus.ch_valid    <= '0;
            bus.frame_valid <= 1'b0;
            if (do_store) begin
                staging                                  <= staging_next;
                bus.ch_data[int'(wr_idx)*WIDTH +: WIDTH] <= bus.in_data;
                bus.ch_valid[wr_idx]                     <= 1'b1;
            end
            if (frame_done) begin
                bus.frame_data  <= staging_next;
                bus.frame_valid <= 1'b1;
            end
        end
    end

endmodule : tdm_demux_4ch
